// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: releases the system reset once PLL lock has settled, re-asserts it on lock loss and counts losses.
// Optional GLITCH_FILTER_EN macro: a loss in RUN then needs FILTER_CYCLES consecutive low lock samples.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             locked,
  output logic             sys_reset_n,
  output logic             ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] loss_count
);
  localparam int MAXC = SETTLE_CYCLES > HOLD_CYCLES ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN, HOLD} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic lock_s;
  logic loss;
  assign lock_s = sync[SYNC_STAGES-1];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], locked};
`ifdef GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  logic [FW-1:0] low_cnt;
  assign loss = !lock_s && low_cnt == FW'(FILTER_CYCLES - 1);
  // Low-run counter only lives in RUN; any high sample or leaving RUN clears it
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) low_cnt <= '0;
    else low_cnt <= (state == RUN && !lock_s && !loss) ? low_cnt + FW'(1) : '0;
`else
  assign loss = !lock_s;
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      loss_count  <= '0;
    end else begin
      lock_lost <= 1'b0;
      case (state)
        WAIT_LOCK:
          if (lock_s) begin
            state <= SETTLE;
            cnt   <= CW'(1);
          end
        SETTLE:
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CW'(SETTLE_CYCLES)) begin
            state       <= RUN;
            cnt         <= '0;
            sys_reset_n <= 1'b1;
            ready       <= 1'b1;
          end else cnt <= cnt + CW'(1);
        RUN:
          if (loss) begin
            state       <= HOLD;
            cnt         <= CW'(1);
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            lock_lost   <= 1'b1;
            loss_count  <= loss_count + CNT_W'(loss_count != '1);
          end
        HOLD:
          if (cnt == CW'(HOLD_CYCLES)) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
        default: state <= WAIT_LOCK;
      endcase
    end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: random lock stimulus against a lock-streak reference model with a scoreboard queue.
module tb_pll_reset_sequencer;
  localparam int SYNC = 2, SETTLE = 8, HOLD = 4, FILT = 3, CNT_W = 2;
`ifdef GLITCH_FILTER_EN
  localparam int LOSS_RUN = FILT;
`else
  localparam int LOSS_RUN = 1;
`endif
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clock = 1'b0, reset_n = 1'b0, locked = 1'b0;
  logic sys_reset_n, ready, lock_lost;
  logic [CNT_W-1:0] loss_count;
  typedef struct packed {
    logic rst_n;
    logic rdy;
    logic pulse;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  exp_t sb[$];
  exp_t got;
  int checks = 0, errors = 0, cyc = 0;
  bit mon_en = 0;
  bit m_run, m_pulse;
  int m_streak, m_low, m_cnt, m_n, m_elig;
  bit sh[SYNC];

  pll_reset_sequencer #(.SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD),
    .FILTER_CYCLES(FILT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .locked(locked), .sys_reset_n(sys_reset_n),
    .ready(ready), .lock_lost(lock_lost), .loss_count(loss_count));

  always #5 clock = ~clock;

  function automatic void chk(string nm, int g, int w);
    checks++;
    if (g != w) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, g, w);
    end
  endfunction

  function automatic void model_reset();
    m_run = 0; m_pulse = 0; m_streak = 0; m_low = 0; m_cnt = 0; m_n = 0; m_elig = 0;
    foreach (sh[i]) sh[i] = 0;
  endfunction

  // Reference: lock_s is 'locked' delayed SYNC edges; RUN after SETTLE+1 consecutive high samples
  // once eligible; a loss blocks lock evaluation for HOLD+1 edges.
  function automatic void model_edge(bit lk);
    exp_t e;
    bit l = sh[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) sh[i] = sh[i-1];
    sh[0] = lk;
    m_n++;
    m_pulse = 0;
    if (m_run) begin
      m_low = l ? 0 : m_low + 1;
      if (m_low == LOSS_RUN) begin
        m_run = 0; m_pulse = 1; m_low = 0;
        if (m_cnt < CMAX) m_cnt++;
        m_elig = m_n + HOLD + 1;
      end
    end else if (m_n >= m_elig) begin
      m_streak = l ? m_streak + 1 : 0;
      if (m_streak == SETTLE + 1) begin
        m_run = 1; m_streak = 0;
      end
    end
    e.rst_n = m_run; e.rdy = m_run; e.pulse = m_pulse; e.cnt = CNT_W'(m_cnt);
    sb.push_back(e);
  endfunction

  task automatic cycle(bit rn, bit lk);
    @(negedge clock);
    if (!rn && reset_n) begin
      reset_n = 1'b0;
      #1;
      chk("async_sys_reset_n", int'(sys_reset_n), 0);
      chk("async_ready", int'(ready), 0);
      chk("async_lock_lost", int'(lock_lost), 0);
      chk("async_loss_count", int'(loss_count), 0);
    end
    reset_n = rn;
    locked = lk;
    if (!rn) begin
      model_reset();
      sb.push_back('0);
    end else model_edge(lk);
    mon_en = 1;
  endtask

  initial forever begin
    @(posedge clock);
    #1;
    cyc++;
    if (mon_en) begin
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty cycle %0d", cyc);
      end else begin
        got = sb.pop_front();
        chk("sys_reset_n", int'(sys_reset_n), int'(got.rst_n));
        chk("ready", int'(ready), int'(got.rdy));
        chk("lock_lost", int'(lock_lost), int'(got.pulse));
        chk("loss_count", int'(loss_count), int'(got.cnt));
      end
    end
  end

  initial begin
    int k;
    model_reset();
    repeat (3) cycle(0, 1);
    #1;
    chk("reset_sys_reset_n", int'(sys_reset_n), 0);
    chk("reset_loss_count", int'(loss_count), 0);
    repeat (16) cycle(1, 1);
    repeat (40) begin
      repeat ($urandom_range(1, 4)) cycle(1, 0);
      repeat ($urandom_range(1, 20)) cycle(1, 1);
    end
    // abort in the middle of a settle period
    repeat (2) cycle(1, 0);
    k = 0;
    while (!(m_streak >= 3 && !m_run) && k < 40) begin cycle(1, 1); k++; end
    if (k == 40) begin errors++; $display("FAIL reach_settle cycle %0d: bound expired", cyc); end
    repeat (2) cycle(0, 1);
    repeat (16) cycle(1, 1);
    // abort in the middle of a hold period after a counted loss
    k = 0;
    while (!m_run && k < 40) begin cycle(1, 1); k++; end
    k = 0;
    while (!(!m_run && m_n < m_elig) && k < 20) begin cycle(1, 0); k++; end
    if (k == 20) begin errors++; $display("FAIL reach_hold cycle %0d: bound expired", cyc); end
    cycle(1, 1);
    repeat (2) cycle(0, 1);
    repeat (30) cycle(1, 1);
    @(posedge clock);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
